// File: rtl/ttl_sim_pkg.sv
// Shared helpers for the TTL chip models: terminal-count helper and a
// time/instance-stamped simulation warning.
package ttl_sim_pkg;

    function automatic int terminal_count(input int modulus);
        return modulus - 1;
    endfunction

`ifndef SYNTHESIS
    task automatic ttl_warn(input string inst, input string msg);
        $display("%t %s: WARNING: %s", $time, inst, msg);
    endtask
`endif

endpackage

// File: rtl/ttl_sync_counter.sv
// Parametrised 74LS160/161/162/163-style synchronous counter with load, clear,
// ENP/ENT enables and ripple carry. Define TTL_CNT_UPDOWN_EN to add up_n ('191-style).
module ttl_sync_counter
    import ttl_sim_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SYNC_CLR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
`ifdef TTL_CNT_UPDOWN_EN
    input  logic             up_n,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam logic [WIDTH-1:0] TC    = WIDTH'(terminal_count(MODULUS));
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             arst;
    logic             down;

`ifdef TTL_CNT_UPDOWN_EN
    assign down = up_n;
`else
    assign down = 1'b0;
`endif

    // Out-of-range states fall back into the sequence on the next count.
    function automatic logic [WIDTH-1:0] next_cnt(input logic [WIDTH-1:0] cur, input logic dn);
        if (dn)
            return (cur == '0 || {1'b0, cur} >= MOD_X) ? TC : cur - 1'b1;
        return (cur >= TC) ? '0 : cur + 1'b1;
    endfunction

    // Asynchronous-clear parts ('160/'161) fold clr_n into the reset path.
    assign arst = rst | (!SYNC_CLR & !clr_n);

    always_comb begin
        q_d = q_q;
        if (SYNC_CLR && !clr_n)
            q_d = '0;
        else if (!load_n)
            q_d = d;
        else if (enp && ent)
            q_d = next_cnt(q_q, down);
`ifndef SYNTHESIS
        if (!(SYNC_CLR && clr_n === 1'b0) && $isunknown({enp, ent, load_n}))
            q_d = 'x;
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && clr_n && !load_n && {1'b0, d} >= MOD_X)
            ttl_warn($sformatf("%m"), $sformatf("load value %0d stored verbatim, >= MODULUS %0d", d, MODULUS));
    end
`endif

    assign q   = q_q;
    assign rco = ent & (down ? (q_q == '0) : (q_q == TC));

endmodule

// File: tb/tb_ttl_sync_counter.sv
// Self-checking bench for ttl_sync_counter: directed table, clear/reset/cascade
// sequences and randomized stimulus against an arithmetic reference model.
module tb_ttl_sync_counter;

    logic       clk = 1'b0;
    logic       rst, clr_n, load_n, enp, ent, up_n;
    logic [3:0] d;
    logic       c_load_n, c_enp, c_ent0;
    logic [3:0] c_d0, c_d1;

    logic [3:0] qA, qB, qC, qL, qH;
    logic       rcoA, rcoB, rcoC, rcoL, rcoH;

    int n_cmp = 0;
    int n_bad = 0;
    int mA, mB, mC, mCas;

    always #5 clk = ~clk;

`ifdef TTL_CNT_UPDOWN_EN
    `define TB_UPN .up_n(up_n),
    `define TB_UPN0 .up_n(1'b0),
`else
    `define TB_UPN
    `define TB_UPN0
`endif

    ttl_sync_counter #(.WIDTH(4), .MODULUS(16), .SYNC_CLR(1'b1)) uA (
        .clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent), `TB_UPN
        .d(d), .q(qA), .rco(rcoA));
    ttl_sync_counter #(.WIDTH(4), .MODULUS(10), .SYNC_CLR(1'b1)) uB (
        .clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent), `TB_UPN
        .d(d), .q(qB), .rco(rcoB));
    ttl_sync_counter #(.WIDTH(4), .MODULUS(16), .SYNC_CLR(1'b0)) uC (
        .clk(clk), .rst(rst), .clr_n(clr_n), .load_n(load_n), .enp(enp), .ent(ent), `TB_UPN
        .d(d), .q(qC), .rco(rcoC));
    ttl_sync_counter #(.WIDTH(4), .MODULUS(16), .SYNC_CLR(1'b1)) uL (
        .clk(clk), .rst(rst), .clr_n(1'b1), .load_n(c_load_n), .enp(c_enp), .ent(c_ent0), `TB_UPN0
        .d(c_d0), .q(qL), .rco(rcoL));
    ttl_sync_counter #(.WIDTH(4), .MODULUS(16), .SYNC_CLR(1'b1)) uH (
        .clk(clk), .rst(rst), .clr_n(1'b1), .load_n(c_load_n), .enp(c_enp), .ent(rcoL), `TB_UPN0
        .d(c_d1), .q(qH), .rco(rcoH));

    // Reference: the counting rules written directly as integer arithmetic.
    function automatic int mnext(int cur, int m, logic ld, logic p, logic t, logic dn, logic [3:0] dd);
        if (rst || !clr_n) return 0;
        if (!ld) return int'(dd);
        if (p && t) begin
            if (dn) return (cur == 0 || cur >= m) ? m - 1 : cur - 1;
            return (cur >= m - 1) ? 0 : cur + 1;
        end
        return cur;
    endfunction

    function automatic logic mrco(int cur, int m);
        return ent && (up_n ? (cur == 0) : (cur == m - 1));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("qA", int'(qA), mA);
        chk("qB", int'(qB), mB);
        chk("qC", int'(qC), mC);
        chk("rcoA", int'(rcoA), int'(mrco(mA, 16)));
        chk("rcoB", int'(rcoB), int'(mrco(mB, 10)));
        chk("rcoC", int'(rcoC), int'(mrco(mC, 16)));
        chk("cascade", int'({qH, qL}), mCas);
        chk("rcoH", int'(rcoH), int'(c_ent0 && mCas == 255));
    endtask

    // Let combinational/asynchronous effects settle, then check.
    task automatic settle();
        #1;
        if (rst) begin mA = 0; mB = 0; mC = 0; mCas = 0; end
        if (!clr_n) mC = 0;
        check_all();
    endtask

    task automatic step();
        int nA, nB, nC, nCas;
        nA = mnext(mA, 16, load_n, enp, ent, up_n, d);
        nB = mnext(mB, 10, load_n, enp, ent, up_n, d);
        nC = mnext(mC, 16, load_n, enp, ent, up_n, d);
        if (rst) nCas = 0;
        else if (!c_load_n) nCas = int'({c_d1, c_d0});
        else if (c_enp && c_ent0) nCas = (mCas + 1) % 256;
        else nCas = mCas;
        @(posedge clk);
        #1;
        mA = nA; mB = nB; mC = nC; mCas = nCas;
        check_all();
    endtask

    typedef struct {
        logic       ld;
        logic       p;
        logic       t;
        logic [3:0] dd;
        int         exp_q;
        logic       exp_rco;
    } vec_t;

    vec_t tbl[21];

    initial begin
        for (int i = 0; i < 12; i++)
            tbl[i] = '{1'b1, 1'b1, 1'b1, 4'h0, (i + 1) % 10, ((i + 1) % 10) == 9};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'hC, 12, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'hD, 13, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 4'h0, 0,  1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 4'h4, 4,  1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 4'h0, 4,  1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 4'h0, 4,  1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 4'h9, 9,  1'b1};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 4'h0, 9,  1'b0};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 4'h0, 0,  1'b0};

        mA = 0; mB = 0; mC = 0; mCas = 0;
        rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; up_n = 1'b0; d = '0;
        c_load_n = 1'b1; c_enp = 1'b0; c_ent0 = 1'b0; c_d0 = '0; c_d1 = '0;
        settle();
        chk("reset_qA", int'(qA), 0);
        @(posedge clk); #1;
        rst = 1'b0; settle();

        // Count to 9, then assert rst between edges.
        enp = 1'b1; ent = 1'b1;
        repeat (9) step();
        chk("count9_qA", int'(qA), 9);
        #3 rst = 1'b1;
        settle();
        chk("async_rst_qA", int'(qA), 0);
        rst = 1'b0;
        settle();
        step();
        chk("post_rst_qA", int'(qA), 1);

        // Decade wrap and load priority table on the MODULUS=10 instance.
        rst = 1'b1; settle(); rst = 1'b0; settle();
        for (int i = 0; i < 21; i++) begin
            load_n = tbl[i].ld; enp = tbl[i].p; ent = tbl[i].t; d = tbl[i].dd;
            step();
            chk($sformatf("tbl%0d_q", i), int'(qB), tbl[i].exp_q);
            chk($sformatf("tbl%0d_rco", i), int'(rcoB), int'(tbl[i].exp_rco));
        end

        // Clear mode: sync parts hold until the edge, async part clears at once.
        load_n = 1'b0; d = 4'h5; enp = 1'b0; ent = 1'b0;
        step();
        load_n = 1'b1;
        settle();
        #2 clr_n = 1'b0;
        settle();
        chk("sync_clr_hold", int'(qA), 5);
        chk("async_clr_now", int'(qC), 0);
        step();
        chk("sync_clr_edge", int'(qA), 0);
        clr_n = 1'b0; load_n = 1'b0; d = 4'h7;
        step();
        chk("clr_over_load", int'(qA), 0);
        clr_n = 1'b1; load_n = 1'b1;
        settle();

        // Cascade: F/3 counts to 0/4; with enp low the carry stays up but nothing moves.
        c_load_n = 1'b0; c_d0 = 4'hF; c_d1 = 4'h3; c_ent0 = 1'b1; c_enp = 1'b0;
        step();
        c_load_n = 1'b1; c_enp = 1'b1;
        settle();
        chk("cas_rcoL", int'(rcoL), 1);
        step();
        chk("cas_q0", int'(qL), 0);
        chk("cas_q1", int'(qH), 4);
        c_load_n = 1'b0; step();
        c_load_n = 1'b1; c_enp = 1'b0;
        step();
        chk("cas_hold_rcoL", int'(rcoL), 1);
        chk("cas_hold_q1", int'(qH), 3);

`ifdef TTL_CNT_UPDOWN_EN
        load_n = 1'b0; d = 4'h1; step();
        load_n = 1'b1; up_n = 1'b1; enp = 1'b1; ent = 1'b1;
        settle();
        step();
        chk("dn_q0", int'(qB), 0);
        chk("dn_rco", int'(rcoB), 1);
        step();
        chk("dn_q9", int'(qB), 9);
        step();
        chk("dn_q8", int'(qB), 8);
        up_n = 1'b0;
        step();
        chk("up_again", int'(qB), 9);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom % 50) == 0;
            clr_n    = ($urandom % 8) != 0;
            load_n   = ($urandom % 4) != 0;
            enp      = ($urandom % 4) != 0;
            ent      = ($urandom % 4) != 0;
            d        = 4'($urandom);
`ifdef TTL_CNT_UPDOWN_EN
            up_n     = 1'($urandom);
`endif
            c_load_n = ($urandom % 16) != 0;
            c_enp    = ($urandom % 4) != 0;
            c_ent0   = ($urandom % 4) != 0;
            c_d0     = 4'($urandom);
            c_d1     = 4'($urandom);
            settle();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
